stage_ex: RTL and testbench

//  Execute stage of the 5-stage MIPS pipeline; sits between the ID/EX latch and the EX/MEM latch and feeds the latter.

---
 rtl/stage_ex_pkg.sv | 51 +++++
 rtl/stage_ex_if.sv | 48 ++++
 rtl/stage_ex_divider.sv | 78 +++++++
 rtl/stage_ex.sv | 115 +++++++++++
 tb/tb_stage_ex.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/stage_ex_pkg.sv
// Execute-stage shared definitions: operator codes, enable/stall levels,
// divider state encoding and the result bundle handed to EX/MEM.
package stage_ex_pkg;

  localparam int DIV_STEPS = 32;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic STALL_ENABLE  = 1'b1;
  localparam logic STALL_DISABLE = 1'b0;

  localparam logic [7:0] EXE_OP_NOP   = 8'b0000_0000;
  localparam logic [7:0] EXE_OP_AND   = 8'b0010_0100;
  localparam logic [7:0] EXE_OP_OR    = 8'b0010_0101;
  localparam logic [7:0] EXE_OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] EXE_OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] EXE_OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] EXE_OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] EXE_OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] EXE_OP_SLT   = 8'b0010_1010;
  localparam logic [7:0] EXE_OP_SLTU  = 8'b0010_1011;
  localparam logic [7:0] EXE_OP_ADD   = 8'b0010_0000;
  localparam logic [7:0] EXE_OP_ADDU  = 8'b0010_0001;
  localparam logic [7:0] EXE_OP_SUB   = 8'b0010_0010;
  localparam logic [7:0] EXE_OP_SUBU  = 8'b0010_0011;
  localparam logic [7:0] EXE_OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] EXE_OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] EXE_OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] EXE_OP_DIVU  = 8'b0001_1011;
  localparam logic [7:0] EXE_OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] EXE_OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] EXE_OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] EXE_OP_MTLO  = 8'b0001_0011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        hi_we;
    logic [31:0] hi;
    logic        lo_we;
    logic [31:0] lo;
  } ex_result_t;

endpackage

// File: rtl/stage_ex_if.sv
// ID/EX-side inputs and EX/MEM-side outputs of the execute stage.
// master = pipeline driving EX, slave = the execute stage itself.
interface stage_ex_if;

  logic [5:0]  stall;
  logic [7:0]  ex_operator;
  logic [31:0] ex_operand_a;
  logic [31:0] ex_operand_b;
  logic        ex_register_write_enable_in;
  logic [4:0]  ex_register_write_address_in;
  logic [31:0] ex_register_hi_read_data;
  logic [31:0] ex_register_lo_read_data;
  logic        ex_register_write_enable;
  logic [4:0]  ex_register_write_address;
  logic [31:0] ex_register_write_data;
  logic        ex_register_hi_write_enable;
  logic [31:0] ex_register_hi_write_data;
  logic        ex_register_lo_write_enable;
  logic [31:0] ex_register_lo_write_data;
  logic        stall_request;

  modport master (
    output stall, ex_operator, ex_operand_a, ex_operand_b,
    output ex_register_write_enable_in,
    output ex_register_write_address_in,
    output ex_register_hi_read_data,
    output ex_register_lo_read_data,
    input  ex_register_write_enable, ex_register_write_address,
    input  ex_register_write_data,
    input  ex_register_hi_write_enable, ex_register_hi_write_data,
    input  ex_register_lo_write_enable, ex_register_lo_write_data,
    input  stall_request
  );

  modport slave (
    input  stall, ex_operator, ex_operand_a, ex_operand_b,
    input  ex_register_write_enable_in,
    input  ex_register_write_address_in,
    input  ex_register_hi_read_data,
    input  ex_register_lo_read_data,
    output ex_register_write_enable, ex_register_write_address,
    output ex_register_write_data,
    output ex_register_hi_write_enable, ex_register_hi_write_data,
    output ex_register_lo_write_enable, ex_register_lo_write_data,
    output stall_request
  );

endinterface

// File: rtl/stage_ex_divider.sv
// Iterative 32-step restoring divider with IDLE/BUSY/DONE control;
// signed divides run on magnitudes and fix signs on the way out.
module ex_divider
  import stage_ex_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic        accept,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_e  state;
  logic [4:0]  count;
  logic [31:0] q, r, d;
  logic        neg_q, neg_r;
  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted, trial;

  assign a_mag   = (is_signed && a[31]) ? -a : a;
  assign b_mag   = (is_signed && b[31]) ? -b : b;
  assign shifted = {r, q[31]};
  assign trial   = shifted - {1'b0, d};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= DIV_IDLE;
      count <= '0;
      q     <= '0;
      r     <= '0;
      d     <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: if (start) begin
          count <= '0;
          if (b == '0) begin
            // divide by zero: all-ones quotient, raw dividend as remainder
            q     <= '1;
            r     <= a;
            d     <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            state <= DIV_DONE;
          end else begin
            q     <= a_mag;
            r     <= '0;
            d     <= b_mag;
            neg_q <= is_signed & (a[31] ^ b[31]);
            neg_r <= is_signed & a[31];
            state <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          r <= trial[32] ? shifted[31:0] : trial[31:0];
          q <= {q[30:0], ~trial[32]};
          if (count == 5'(DIV_STEPS - 1)) state <= DIV_DONE;
          else count <= count + 5'd1;
        end
        DIV_DONE: if (accept) state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

  assign busy      = (state == DIV_IDLE && start) || state == DIV_BUSY;
  assign done      = (state == DIV_DONE);
  assign quotient  = neg_q ? -q : q;
  assign remainder = neg_r ? -r : r;

endmodule

// File: rtl/stage_ex.sv
// MIPS execute stage: single-cycle ALU, shifts, compares, multiply and
// HI/LO moves; divides go to ex_divider and stall the pipe until done.
module stage_ex
  import stage_ex_pkg::*;
(
  input logic   clock,
  input logic   reset,
  stage_ex_if.slave ex
);

  logic [7:0]  op;
  logic [31:0] a, b;
  logic [31:0] sum, diff;
  logic        add_ovf, sub_ovf;
  logic [63:0] prod_s, prod_u;
  logic        div_start, div_busy, div_done;
  logic [31:0] div_q, div_r;
  logic        unused_stall;
  ex_result_t  res;

  assign op = ex.ex_operator;
  assign a  = ex.ex_operand_a;
  assign b  = ex.ex_operand_b;

  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
  assign sub_ovf = (a[31] != b[31]) && (diff[31] != a[31]);
  assign prod_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u  = {32'd0, a} * {32'd0, b};

  assign div_start    = (op == EXE_OP_DIV) || (op == EXE_OP_DIVU);
  assign unused_stall = ^{ex.stall[5:4], ex.stall[2:0]};

  ex_divider u_div (
    .clock     (clock),
    .reset     (reset),
    .start     (div_start),
    .is_signed (op == EXE_OP_DIV),
    .accept    (~ex.stall[3]),
    .a         (a),
    .b         (b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_comb begin
    res       = '0;
    res.waddr = ex.ex_register_write_address_in;
    res.wen   = ex.ex_register_write_enable_in;
    unique case (op)
      EXE_OP_AND:  res.wdata = a & b;
      EXE_OP_OR:   res.wdata = a | b;
      EXE_OP_XOR:  res.wdata = a ^ b;
      EXE_OP_NOR:  res.wdata = ~(a | b);
      EXE_OP_SLL:  res.wdata = b << a[4:0];
      EXE_OP_SRL:  res.wdata = b >> a[4:0];
      EXE_OP_SRA:  res.wdata = $unsigned($signed(b) >>> a[4:0]);
      EXE_OP_SLT:  res.wdata = {31'd0, $signed(a) < $signed(b)};
      EXE_OP_SLTU: res.wdata = {31'd0, a < b};
      EXE_OP_ADDU: res.wdata = sum;
      EXE_OP_SUBU: res.wdata = diff;
      EXE_OP_MFHI: res.wdata = ex.ex_register_hi_read_data;
      EXE_OP_MFLO: res.wdata = ex.ex_register_lo_read_data;
      EXE_OP_ADD: begin
        res.wdata = sum;
        if (add_ovf) res.wen = WRITE_DISABLE;
      end
      EXE_OP_SUB: begin
        res.wdata = diff;
        if (sub_ovf) res.wen = WRITE_DISABLE;
      end
      EXE_OP_MULT, EXE_OP_MULTU: begin
        res       = '0;
        res.hi_we = WRITE_ENABLE;
        res.lo_we = WRITE_ENABLE;
        res.hi    = (op == EXE_OP_MULT) ? prod_s[63:32] : prod_u[63:32];
        res.lo    = (op == EXE_OP_MULT) ? prod_s[31:0] : prod_u[31:0];
      end
      EXE_OP_MTHI: begin
        res       = '0;
        res.hi_we = WRITE_ENABLE;
        res.hi    = a;
      end
      EXE_OP_MTLO: begin
        res       = '0;
        res.lo_we = WRITE_ENABLE;
        res.lo    = a;
      end
      default: res = '0;
    endcase
    // divider owns the outputs from the start cycle until the result leaves
    if (div_busy || div_done) begin
      res = '0;
      if (div_done) begin
        res.hi_we = WRITE_ENABLE;
        res.lo_we = WRITE_ENABLE;
        res.hi    = div_r;
        res.lo    = div_q;
      end
    end
  end

  assign ex.ex_register_write_enable    = res.wen;
  assign ex.ex_register_write_address   = res.waddr;
  assign ex.ex_register_write_data      = res.wdata;
  assign ex.ex_register_hi_write_enable = res.hi_we;
  assign ex.ex_register_hi_write_data   = res.hi;
  assign ex.ex_register_lo_write_enable = res.lo_we;
  assign ex.ex_register_lo_write_data   = res.lo;
  assign ex.stall_request = div_busy ? STALL_ENABLE : STALL_DISABLE;

endmodule

// File: tb/tb_stage_ex.sv
// Directed bench for stage_ex: ALU, multiply, moves, divider latency,
// signed/zero divides, DONE hold and reset during a divide.
module tb_stage_ex;
  import stage_ex_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic hold  = 1'b0;
  int   errors = 0;
  int   checks = 0;

  stage_ex_if bus ();

  stage_ex dut (
    .clock (clock),
    .reset (reset),
    .ex    (bus)
  );

  always #5 clock = ~clock;

  // stall[3] follows the stage's own request, optionally held high
  always_comb bus.stall = {2'b00, bus.stall_request | hold, 3'b000};

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] oa,
                       input logic [31:0] ob);
    bus.ex_operator  = op;
    bus.ex_operand_a = oa;
    bus.ex_operand_b = ob;
  endtask

  task automatic run_div(input string tag, input logic [7:0] op,
                         input logic [31:0] oa, input logic [31:0] ob,
                         input int exp_stalls, input logic [31:0] eq,
                         input logic [31:0] er, input int holds);
    int n;
    n = 0;
    @(posedge clock); #1;
    drive(op, oa, ob);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!bus.stall_request) break;
      n++;
    end
    check({tag, " stalls"}, 32'(n), 32'(exp_stalls));
    check({tag, " lo"}, bus.ex_register_lo_write_data, eq);
    check({tag, " hi"}, bus.ex_register_hi_write_data, er);
    check({tag, " we"}, {30'd0, bus.ex_register_hi_write_enable,
          bus.ex_register_lo_write_enable}, 32'd3);
    if (holds > 0) begin
      hold = 1'b1;
      for (int h = 0; h < holds; h++) begin
        @(negedge clock);
        check({tag, " held lo"}, bus.ex_register_lo_write_data, eq);
      end
      hold = 1'b0;
    end
    @(posedge clock); #1;
    drive(EXE_OP_NOP, 32'd0, 32'd0);
    @(negedge clock);
    check({tag, " after"}, {30'd0, bus.stall_request,
          bus.ex_register_lo_write_enable}, 32'd0);
  endtask

  initial begin
    drive(EXE_OP_NOP, 32'd0, 32'd0);
    bus.ex_register_write_enable_in  = 1'b0;
    bus.ex_register_write_address_in = 5'd0;
    bus.ex_register_hi_read_data     = 32'd0;
    bus.ex_register_lo_read_data     = 32'd0;
    repeat (2) @(negedge clock);
    check("rst stall", {31'd0, bus.stall_request}, 32'd0);
    check("rst we", {29'd0, bus.ex_register_write_enable,
          bus.ex_register_hi_write_enable,
          bus.ex_register_lo_write_enable}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    bus.ex_register_write_enable_in  = 1'b1;
    bus.ex_register_write_address_in = 5'd5;
    drive(EXE_OP_ADD, 32'h7FFF_FFFF, 32'd1); #1;
    check("add ovf wen", {31'd0, bus.ex_register_write_enable}, 32'd0);
    drive(EXE_OP_ADDU, 32'h7FFF_FFFF, 32'd1); #1;
    check("addu data", bus.ex_register_write_data, 32'h8000_0000);
    check("addu wen", {31'd0, bus.ex_register_write_enable}, 32'd1);
    check("addu addr", {27'd0, bus.ex_register_write_address}, 32'd5);
    drive(EXE_OP_SUB, 32'h8000_0000, 32'd1); #1;
    check("sub ovf wen", {31'd0, bus.ex_register_write_enable}, 32'd0);
    drive(EXE_OP_SUB, 32'd3, 32'd5); #1;
    check("sub data", bus.ex_register_write_data, 32'hFFFF_FFFE);
    drive(EXE_OP_SLT, 32'hFFFF_FFFF, 32'd1); #1;
    check("slt", bus.ex_register_write_data, 32'd1);
    drive(EXE_OP_SLTU, 32'hFFFF_FFFF, 32'd1); #1;
    check("sltu", bus.ex_register_write_data, 32'd0);
    drive(EXE_OP_SRA, 32'd36, 32'h8000_0000); #1;
    check("sra", bus.ex_register_write_data, 32'hF800_0000);
    drive(EXE_OP_SRL, 32'd4, 32'h8000_0000); #1;
    check("srl", bus.ex_register_write_data, 32'h0800_0000);
    drive(EXE_OP_SLL, 32'd4, 32'd1); #1;
    check("sll", bus.ex_register_write_data, 32'h10);
    drive(EXE_OP_NOR, 32'h0F0F_0000, 32'h0000_00FF); #1;
    check("nor", bus.ex_register_write_data, 32'hF0F0_FF00);
    bus.ex_register_hi_read_data = 32'h1234_5678;
    bus.ex_register_lo_read_data = 32'h9ABC_DEF0;
    drive(EXE_OP_MFHI, 32'd0, 32'd0); #1;
    check("mfhi", bus.ex_register_write_data, 32'h1234_5678);
    drive(EXE_OP_MFLO, 32'd0, 32'd0); #1;
    check("mflo", bus.ex_register_write_data, 32'h9ABC_DEF0);
    bus.ex_register_write_enable_in = 1'b0;
    drive(EXE_OP_MTLO, 32'hABCD, 32'd0); #1;
    check("mtlo", bus.ex_register_lo_write_data, 32'hABCD);
    check("mtlo we", {30'd0, bus.ex_register_hi_write_enable,
          bus.ex_register_lo_write_enable}, 32'd1);
    drive(EXE_OP_MTHI, 32'h55, 32'd0); #1;
    check("mthi", bus.ex_register_hi_write_data, 32'h55);
    drive(EXE_OP_MULT, 32'hFFFF_FFFE, 32'd3); #1;
    check("mult hi", bus.ex_register_hi_write_data, 32'hFFFF_FFFF);
    check("mult lo", bus.ex_register_lo_write_data, 32'hFFFF_FFFA);
    check("mult we", {30'd0, bus.ex_register_hi_write_enable,
          bus.ex_register_lo_write_enable}, 32'd3);
    drive(EXE_OP_MULTU, 32'hFFFF_FFFE, 32'd3); #1;
    check("multu hi", bus.ex_register_hi_write_data, 32'h2);
    check("multu lo", bus.ex_register_lo_write_data, 32'hFFFF_FFFA);
    bus.ex_register_write_enable_in = 1'b1;
    drive(8'hFF, 32'h1, 32'h2); #1;
    check("unknown", {bus.ex_register_write_enable,
          bus.ex_register_hi_write_enable,
          bus.ex_register_lo_write_enable,
          29'd0}, 32'd0);
    check("unknown data", bus.ex_register_write_data, 32'd0);
    bus.ex_register_write_enable_in = 1'b0;
    drive(EXE_OP_NOP, 32'd0, 32'd0);

    run_div("divu", EXE_OP_DIVU, 32'd100, 32'd7, 33, 32'd14, 32'd2, 0);
    run_div("div n", EXE_OP_DIV, -32'sd7, 32'd2, 33,
            32'hFFFF_FFFD, 32'hFFFF_FFFF, 2);
    run_div("div p", EXE_OP_DIV, 32'd7, -32'sd2, 33,
            32'hFFFF_FFFD, 32'd1, 0);
    run_div("div0", EXE_OP_DIV, 32'd5, 32'd0, 1,
            32'hFFFF_FFFF, 32'd5, 0);

    @(posedge clock); #1;
    drive(EXE_OP_DIVU, 32'hFFFF_FFFF, 32'd1);
    repeat (11) @(posedge clock);
    #1;
    drive(EXE_OP_NOP, 32'd0, 32'd0);
    @(negedge clock);
    check("mid busy", {31'd0, bus.stall_request}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("mid rst stall", {31'd0, bus.stall_request}, 32'd0);
    check("mid rst we", {30'd0, bus.ex_register_hi_write_enable,
          bus.ex_register_lo_write_enable}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    run_div("post rst", EXE_OP_DIVU, 32'd9, 32'd3, 33, 32'd3, 32'd0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
